// File: rtl/npc_pkg.sv
// Shared npc core definitions: load funct3 encodings, writeback FSM states and
// the default datapath width.
package npc_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic {
      WB_IDLE     = 1'b0,
      WB_WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

// File: rtl/load_ext.sv
// Load lane selection and sign/zero extension for the writeback stage; flags
// illegal funct3 encodings and misaligned halfword/word accesses.
module load_ext
   import npc_pkg::*;
#(
   parameter int DW = DATA_WIDTH
) (
   input  logic [2:0]    load_fn,
   input  logic [1:0]    addr_lo,
   input  logic [DW-1:0] rdata,
   output logic [DW-1:0] data,
   output logic          err
);

   logic [DW-1:0] lane_s;

   // select the addressed lane and extend it according to funct3
   always_comb begin
      lane_s = rdata >> {addr_lo, 3'b000};
      data   = {DW{1'b0}};
      err    = 1'b0;
      case (load_fn)
         LB:  data = {{(DW-8){lane_s[7]}}, lane_s[7:0]};
         LBU: data = {{(DW-8){1'b0}}, lane_s[7:0]};
         LH: begin
            if (addr_lo[0]) begin
               err = 1'b1;
            end else begin
               data = {{(DW-16){lane_s[15]}}, lane_s[15:0]};
            end
         end
         LHU: begin
            if (addr_lo[0]) begin
               err = 1'b1;
            end else begin
               data = {{(DW-16){1'b0}}, lane_s[15:0]};
            end
         end
         LW: begin
            if (addr_lo != 2'b00) begin
               err = 1'b1;
            end else begin
               data = rdata;
            end
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts ALU results or pending loads, waits for load data,
// and issues one registered register-file write / retire pulse per instruction.
module wb_stage
   import npc_pkg::*;
#(
   parameter int DATA_WIDTH  = npc_pkg::DATA_WIDTH,
   parameter int REG_NUM_BIT = 5,
   parameter int CNT_WIDTH   = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [REG_NUM_BIT-1:0] in_rd,
   input  logic                   in_rd_wen,
   input  logic                   in_is_load,
   input  logic [2:0]             in_load_fn,
   input  logic [1:0]             in_addr_lo,
   input  logic [DATA_WIDTH-1:0]  in_alu_result,
   input  logic                   mem_rvalid,
   input  logic [DATA_WIDTH-1:0]  mem_rdata,
   output logic [REG_NUM_BIT-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]  rf_wdata,
   output logic                   rf_wen,
   output logic                   retire,
   output logic                   load_err,
   output logic [CNT_WIDTH-1:0]   ret_cnt
);

   wb_state_e              state_q, state_d;
   logic [REG_NUM_BIT-1:0] rd_q, rd_d;
   logic                   rd_wen_q, rd_wen_d;
   logic [2:0]             load_fn_q, load_fn_d;
   logic [1:0]             addr_lo_q, addr_lo_d;
   logic [REG_NUM_BIT-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
   logic                   rf_wen_q, rf_wen_d;
   logic                   retire_q, retire_d;
   logic                   load_err_q, load_err_d;
   logic [CNT_WIDTH-1:0]   ret_cnt_q, ret_cnt_d;
   logic                   accept_s;
   logic [DATA_WIDTH-1:0]  ext_data_s;
   logic                   ext_err_s;

   load_ext #(.DW(DATA_WIDTH)) u_load_ext (
      .load_fn (load_fn_q),
      .addr_lo (addr_lo_q),
      .rdata   (mem_rdata),
      .data    (ext_data_s),
      .err     (ext_err_s)
   );

   assign accept_s = in_valid & in_ready;

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WB_IDLE;
         rd_q       <= {REG_NUM_BIT{1'b0}};
         rd_wen_q   <= 1'b0;
         load_fn_q  <= 3'b000;
         addr_lo_q  <= 2'b00;
         rf_waddr_q <= {REG_NUM_BIT{1'b0}};
         rf_wdata_q <= {DATA_WIDTH{1'b0}};
         rf_wen_q   <= 1'b0;
         retire_q   <= 1'b0;
         load_err_q <= 1'b0;
         ret_cnt_q  <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         rd_wen_q   <= rd_wen_d;
         load_fn_q  <= load_fn_d;
         addr_lo_q  <= addr_lo_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_wen_q   <= rf_wen_d;
         retire_q   <= retire_d;
         load_err_q <= load_err_d;
         ret_cnt_q  <= ret_cnt_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE: begin
            if (accept_s && in_is_load) begin
               state_d = WB_WAIT_MEM;
            end else begin
               state_d = WB_IDLE;
            end
         end
         WB_WAIT_MEM: begin
            if (mem_rvalid) begin
               state_d = WB_IDLE;
            end else begin
               state_d = WB_WAIT_MEM;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      case (state_q)
         WB_IDLE:     in_ready = 1'b1;
         WB_WAIT_MEM: in_ready = 1'b0;
         default:     in_ready = 1'b0;
      endcase
   end

   // field latches, write/retire generation and retire counter
   always_comb begin
      rd_d       = rd_q;
      rd_wen_d   = rd_wen_q;
      load_fn_d  = load_fn_q;
      addr_lo_d  = addr_lo_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_wen_d   = 1'b0;
      retire_d   = 1'b0;
      load_err_d = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (accept_s) begin
               rd_d      = in_rd;
               rd_wen_d  = in_rd_wen;
               load_fn_d = in_load_fn;
               addr_lo_d = in_addr_lo;
               if (!in_is_load) begin
                  retire_d = 1'b1;
                  rf_wen_d = in_rd_wen & (in_rd != {REG_NUM_BIT{1'b0}});
                  if (rf_wen_d) begin
                     rf_waddr_d = in_rd;
                     rf_wdata_d = in_alu_result;
                  end else begin
                     rf_waddr_d = rf_waddr_q;
                  end
               end else begin
                  retire_d = 1'b0;
               end
            end else begin
               rd_d = rd_q;
            end
         end
         WB_WAIT_MEM: begin
            if (mem_rvalid) begin
               retire_d   = 1'b1;
               load_err_d = ext_err_s;
               rf_wen_d   = rd_wen_q & (rd_q != {REG_NUM_BIT{1'b0}}) & ~ext_err_s;
               if (rf_wen_d) begin
                  rf_waddr_d = rd_q;
                  rf_wdata_d = ext_data_s;
               end else begin
                  rf_waddr_d = rf_waddr_q;
               end
            end else begin
               retire_d = 1'b0;
            end
         end
         default: retire_d = 1'b0;
      endcase
      ret_cnt_d = ret_cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire_d};
   end

   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign rf_wen   = rf_wen_q;
   assign retire   = retire_q;
   assign load_err = load_err_q;
   assign ret_cnt  = ret_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: inputs driven on negedge, outputs sampled on
// the following negedge, i.e. after the posedge that consumed them.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic        in_is_load;
   logic [2:0]  in_load_fn;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu_result;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_wen;
   logic        retire;
   logic        load_err;
   logic [63:0] ret_cnt;

   int checks = 0;
   int errors = 0;

   wb_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
      .in_load_fn(in_load_fn), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .rf_wen(rf_wen), .retire(retire), .load_err(load_err),
      .ret_cnt(ret_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_rd_wen = 1'b1;
      in_alu_result = res; in_load_fn = 3'b000; in_addr_lo = 2'b00;
   endtask

   task automatic drive_load(input logic [4:0] rd, input logic [2:0] fn, input logic [1:0] lo);
      in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_rd_wen = 1'b1;
      in_alu_result = 32'hDEAD_DEAD; in_load_fn = fn; in_addr_lo = lo;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_rd_wen = 1'b0; in_is_load = 1'b0;
      in_load_fn = 3'b000; in_addr_lo = 2'b00; in_alu_result = 32'h0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %b exp 0", rf_wen); end
      checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got %0d exp 0", rf_waddr); end
      checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf_wdata got %h exp 0", rf_wdata); end
      checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_retire got %b exp 0", retire); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b exp 0", load_err); end
      checks++; if (ret_cnt !== 64'd0) begin errors++; $display("FAIL reset_ret_cnt got %0d exp 0", ret_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_alu_back_to_back();
      drive_alu(5'd5, 32'h11);
      @(negedge clk);
      checks++; if ({rf_wen, retire, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd5, 32'h11})
         begin errors++; $display("FAIL alu1 got wen=%b ret=%b a=%0d d=%h exp 1 1 5 11", rf_wen, retire, rf_waddr, rf_wdata); end
      drive_alu(5'd6, 32'h22);
      @(negedge clk);
      checks++; if ({rf_wen, retire, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd6, 32'h22})
         begin errors++; $display("FAIL alu2 got wen=%b ret=%b a=%0d d=%h exp 1 1 6 22", rf_wen, retire, rf_waddr, rf_wdata); end
      drive_alu(5'd0, 32'h33);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if ({rf_wen, retire, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd6, 32'h22})
         begin errors++; $display("FAIL alu_rd0 got wen=%b ret=%b a=%0d d=%h exp 0 1 6 22", rf_wen, retire, rf_waddr, rf_wdata); end
      @(negedge clk);
      checks++; if ({rf_wen, retire} !== 2'b00) begin errors++; $display("FAIL alu_idle got wen/ret=%b exp 00", {rf_wen, retire}); end
      checks++; if (ret_cnt !== 64'd3) begin errors++; $display("FAIL alu_ret_cnt got %0d exp 3", ret_cnt); end
   endtask

   task automatic test_lb_sign();
      drive_load(5'd7, 3'b000, 2'd3);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000; end
         checks++; if ({in_ready, rf_wen, retire} !== 3'b000)
            begin errors++; $display("FAIL lb_wait%0d got rdy/wen/ret=%b exp 000", i, {in_ready, rf_wen, retire}); end
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
      checks++; if ({rf_wen, retire, load_err, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 1'b0, 5'd7, 32'hFFFF_FF80})
         begin errors++; $display("FAIL lb_sign got wen=%b ret=%b err=%b a=%0d d=%h exp 1 1 0 7 ffffff80", rf_wen, retire, load_err, rf_waddr, rf_wdata); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_after got %b exp 1", in_ready); end
      checks++; if (ret_cnt !== 64'd4) begin errors++; $display("FAIL lb_ret_cnt got %0d exp 4", ret_cnt); end
   endtask

   task automatic test_lhu_offset();
      drive_load(5'd9, 3'b101, 2'd2);
      @(negedge clk);
      in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_1234;
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++; if ({rf_wen, retire, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd9, 32'h0000_BEEF})
         begin errors++; $display("FAIL lhu got wen=%b ret=%b a=%0d d=%h exp 1 1 9 0000beef", rf_wen, retire, rf_waddr, rf_wdata); end
      @(negedge clk);
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL lhu_single_pulse got %b exp 0", rf_wen); end
   endtask

   task automatic test_errors();
      logic [2:0]  fns [2] = '{3'b010, 3'b011};
      logic [1:0]  los [2] = '{2'd1, 2'd0};
      logic [63:0] cnts[2] = '{64'd6, 64'd7};
      for (int i = 0; i < 2; i++) begin
         drive_load(5'd10, fns[i], los[i]);
         @(negedge clk);
         in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
         @(negedge clk);
         mem_rvalid = 1'b0;
         checks++; if ({load_err, retire, rf_wen, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_BEEF})
            begin errors++; $display("FAIL err%0d got err=%b ret=%b wen=%b a=%0d d=%h exp 1 1 0 9 0000beef", i, load_err, retire, rf_wen, rf_waddr, rf_wdata); end
         checks++; if (ret_cnt !== cnts[i]) begin errors++; $display("FAIL err%0d_ret_cnt got %0d exp %0d", i, ret_cnt, cnts[i]); end
      end
      @(negedge clk);
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", load_err); end
   endtask

   task automatic test_reset_mid_load();
      drive_load(5'd12, 3'b010, 2'd0);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({in_ready, rf_wen, retire, ret_cnt} !== {1'b1, 1'b0, 1'b0, 64'd0})
         begin errors++; $display("FAIL rst_mid got rdy=%b wen=%b ret=%b cnt=%0d exp 1 0 0 0", in_ready, rf_wen, retire, ret_cnt); end
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++; if ({rf_wen, retire, ret_cnt} !== {1'b0, 1'b0, 64'd0})
         begin errors++; $display("FAIL rst_late_rvalid got wen=%b ret=%b cnt=%0d exp 0 0 0", rf_wen, retire, ret_cnt); end
   endtask

   task automatic test_stale_rvalid();
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++; if ({rf_wen, retire, in_ready} !== 3'b001)
         begin errors++; $display("FAIL stale got wen/ret/rdy=%b exp 001", {rf_wen, retire, in_ready}); end
      drive_alu(5'd3, 32'hA5);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if ({rf_wen, rf_waddr, rf_wdata, ret_cnt} !== {1'b1, 5'd3, 32'hA5, 64'd1})
         begin errors++; $display("FAIL post_stale_alu got wen=%b a=%0d d=%h cnt=%0d exp 1 3 a5 1", rf_wen, rf_waddr, rf_wdata, ret_cnt); end
   endtask

   initial begin
      test_reset();
      test_alu_back_to_back();
      test_lb_sign();
      test_lhu_offset();
      test_errors();
      test_reset_mid_load();
      test_stale_rvalid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
